// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_DEBUG = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } arb_state_t;

    // One-hot requester vector from a requester index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational requester picker: fixed priority data > fetch > debug,
// except that a starving debug requester wins outright.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               starve_hit,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx
);

    // Pick at most one requester; nothing granted when none are valid.
    always_comb begin
        grant     = '0;
        grant_idx = 2'd0;
        if (starve_hit && req_valid[REQ_DEBUG]) begin
            grant_idx = 2'(REQ_DEBUG);
        end else if (req_valid[REQ_DATA]) begin
            grant_idx = 2'(REQ_DATA);
        end else if (req_valid[REQ_FETCH]) begin
            grant_idx = 2'(REQ_FETCH);
        end else if (req_valid[REQ_DEBUG]) begin
            grant_idx = 2'(REQ_DEBUG);
        end
        if (|req_valid) begin
            grant = req_onehot(grant_idx);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single synchronous-read memory port shared by
// data load/store, instruction fetch and the debug loader.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrating every cycle
// ACCESS  | mem_en pulse with the registered request fields
// WAIT    | counting down the memory's extra latency
// CAPTURE | registering mem_rdata (zero for writes)
// RESP    | rsp_valid to owner; may grant the next access in parallel
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic [1:0]                    owner
);

    localparam int         STRB_W     = DATA_W / 8;
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [3:0]           wait_cnt;
    logic [3:0]           starve_cnt;
    logic                 starve_hit;
    logic                 arb_window;
    logic                 grant_fire;
    logic [NUM_REQ-1:0]   pick;
    logic [1:0]           pick_idx;
    logic                 tx_we;

    assign starve_hit = (starve_cnt >= STARVE_LIM);
    assign arb_window = (state == ST_IDLE) || (state == ST_RESP);

    mem_arb_prio u_prio (
        .req_valid  (req_valid),
        .starve_hit (starve_hit),
        .grant      (pick),
        .grant_idx  (pick_idx)
    );

    // Accept pulse is only offered at arbitration points; held off while in reset.
    assign req_ready  = (arb_window && !reset) ? pick : '0;
    assign grant_fire = |req_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the fixed access sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_fire) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = grant_fire ? ST_ACCESS : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Wait-state down-counter, loaded on the way out of ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_ACCESS) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Debug starvation counter: counts grants that bypass a waiting debug request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!req_valid[REQ_DEBUG]) begin
            starve_cnt <= 4'd0;
        end else if (grant_fire) begin
            if (pick_idx == 2'(REQ_DEBUG)) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Request fields, owner and memory strobes registered on the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            tx_we     <= 1'b0;
            owner     <= 2'd0;
            busy      <= 1'b0;
        end else begin
            mem_en <= grant_fire;
            mem_we <= grant_fire && req_we[pick_idx];
            busy   <= (state_next != ST_IDLE);
            if (grant_fire) begin
                mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                mem_wstrb <= req_wstrb[pick_idx*STRB_W +: STRB_W];
                tx_we     <= req_we[pick_idx];
                owner     <= pick_idx;
            end else if (state_next == ST_IDLE) begin
                owner <= 2'd0;
            end
        end
    end

    // Capture read data (writes return zero) and pulse the owner's response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == ST_CAPTURE) ? req_onehot(owner) : '0;
            if (state == ST_CAPTURE) begin
                rsp_rdata <= tx_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (0 and 3 wait states) sharing
// stimulus, each with its own latency-accurate memory model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req_valid;
    logic [2:0]    req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [3*SW-1:0] req_wstrb;

    logic [2:0]    rdy    [2];
    logic [2:0]    rspv   [2];
    logic [DW-1:0] rspd   [2];
    logic          men    [2];
    logic          mwe    [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic [SW-1:0] mwstrb [2];
    logic [DW-1:0] mrdata [2];
    logic          bsy    [2];
    logic [1:0]    own    [2];

    int            cyc = 0;
    int            rdy_cyc [2];
    logic [DW-1:0] rd_word [2];
    logic [DW-1:0] mem     [2][64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .STARVE_LIMIT(8)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(rdy[0]), .rsp_valid(rspv[0]), .rsp_rdata(rspd[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_wstrb(mwstrb[0]), .mem_rdata(mrdata[0]), .busy(bsy[0]), .owner(own[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3), .STARVE_LIMIT(8)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(rdy[1]), .rsp_valid(rspv[1]), .rsp_rdata(rspd[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_wstrb(mwstrb[1]), .mem_rdata(mrdata[1]), .busy(bsy[1]), .owner(own[1])
    );

    // Read data is garbage until the configured latency after mem_en has elapsed.
    assign mrdata[0] = (cyc >= rdy_cyc[0]) ? rd_word[0] : 32'hBAD0_BAD0;
    assign mrdata[1] = (cyc >= rdy_cyc[1]) ? rd_word[1] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int i = 0; i < 64; i++) mem[d][i] <= init_word(i);
                rdy_cyc[d] <= 0;
                rd_word[d] <= '0;
            end else if (men[d]) begin
                rd_word[d] <= mem[d][maddr[d][7:2]];
                rdy_cyc[d] <= cyc + 1 + ws(d);
                if (mwe[d]) begin
                    for (int b = 0; b < SW; b++)
                        if (mwstrb[d][b]) mem[d][maddr[d][7:2]][8*b +: 8] <= mwdata[d][8*b +: 8];
                end
            end
        end
    end

    task automatic wait_grant(input int d, output logic [2:0] g, output int t);
        g = 3'b000;
        t = -1;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (rdy[d] !== 3'b000) begin
                g = rdy[d];
                t = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        req_valid = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = wd;
        req_wstrb[i*SW +: SW] = st;
        req_valid[i]         = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (rdy[d] !== 3'b0) begin errors++; $display("FAIL reset_ready dut%0d got=%b want=000", d, rdy[d]); end
            checks++; if (rspv[d] !== 3'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d got=%b want=000", d, rspv[d]); end
            checks++; if (rspd[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata dut%0d got=%h want=0", d, rspd[d]); end
            checks++; if ({men[d], mwe[d]} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we dut%0d got=%b want=00", d, {men[d], mwe[d]}); end
            checks++; if ({maddr[d], mwdata[d], mwstrb[d]} !== '0) begin errors++; $display("FAIL reset_mem_fields dut%0d got=%h/%h/%h want=0", d, maddr[d], mwdata[d], mwstrb[d]); end
            checks++; if ({bsy[d], own[d]} !== 3'b000) begin errors++; $display("FAIL reset_busy_owner dut%0d got=%b/%0d want=0/0", d, bsy[d], own[d]); end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [2:0] g; int t;
        drain();
        set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_grant(0, g, t);
        checks++; if (g !== 3'b010) begin errors++; $display("FAIL read_ready got=%b want=010", g); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (men[0] !== 1'b1 || mwe[0] !== 1'b0 || maddr[0] !== 32'h10) begin
            errors++; $display("FAIL read_mem_strobe got en=%b we=%b addr=%h want en=1 we=0 addr=10", men[0], mwe[0], maddr[0]); end
        checks++; if (bsy[0] !== 1'b1 || own[0] !== 2'd1) begin errors++; $display("FAIL read_busy_owner got=%b/%0d want=1/1", bsy[0], own[0]); end
        @(negedge clk);
        checks++; if (rspv[0] !== 3'b000 || men[0] !== 1'b0) begin errors++; $display("FAIL read_early_rsp got rsp=%b en=%b want 000/0", rspv[0], men[0]); end
        @(negedge clk);
        checks++; if (rspv[0] !== 3'b010 || cyc != t + 3) begin errors++; $display("FAIL read_rsp_valid got=%b at T+%0d want=010 at T+3", rspv[0], cyc - t); end
        checks++; if (rspd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got=%h want=deadbeef", rspd[0]); end
        @(negedge clk);
        checks++; if (rspv[0] !== 3'b000 || bsy[0] !== 1'b0 || own[0] !== 2'd0) begin
            errors++; $display("FAIL read_idle_after got rsp=%b busy=%b owner=%0d want 000/0/0", rspv[0], bsy[0], own[0]); end
    endtask

    task automatic test_write();
        logic [2:0] g; int t;
        drain();
        set_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        wait_grant(0, g, t);
        checks++; if (g !== 3'b001) begin errors++; $display("FAIL write_ready got=%b want=001", g); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (men[0] !== 1'b1 || mwe[0] !== 1'b1) begin errors++; $display("FAIL write_strobes got en=%b we=%b want 1/1", men[0], mwe[0]); end
        checks++; if (maddr[0] !== 32'h20 || mwdata[0] !== 32'h12345678 || mwstrb[0] !== 4'hF) begin
            errors++; $display("FAIL write_fields got %h/%h/%h want 20/12345678/f", maddr[0], mwdata[0], mwstrb[0]); end
        repeat (2) @(negedge clk);
        checks++; if (rspv[0] !== 3'b001 || rspd[0] !== 32'h0 || cyc != t + 3) begin
            errors++; $display("FAIL write_rsp got=%b data=%h at T+%0d want=001 data=0 at T+3", rspv[0], rspd[0], cyc - t); end
        checks++; if (mem[0][8] !== 32'h12345678) begin errors++; $display("FAIL write_mem got=%h want=12345678", mem[0][8]); end
    endtask

    task automatic test_contention();
        logic [2:0] g; int t;
        logic [2:0] want;
        drain();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 9; k++) begin
            wait_grant(0, g, t);
            want = (k < 8) ? 3'b001 : 3'b100;
            checks++; if (g !== want) begin errors++; $display("FAIL contention_all grant#%0d got=%b want=%b", k, g, want); end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wait_grant(0, g, t);
            want = (k < 8) ? 3'b010 : 3'b100;
            checks++; if (g !== want) begin errors++; $display("FAIL contention_no0 grant#%0d got=%b want=%b", k, g, want); end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_wait_states();
        int g_q[$], e_q[$], r_q[$];
        logic [31:0] d_q[$];
        logic granted;
        int ngr = 0;
        drain();
        set_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int n = 0; n < 20; n++) begin
            #1;
            granted = (rdy[1] !== 3'b000);
            if (granted) g_q.push_back(cyc);
            if (men[1] === 1'b1) e_q.push_back(cyc);
            if (rspv[1] !== 3'b000) begin r_q.push_back(cyc); d_q.push_back(rspd[1]); end
            @(negedge clk);
            if (granted) begin
                ngr++;
                if (ngr == 3) req_valid = '0;
                else req_addr[0 +: AW] = req_addr[0 +: AW] + 32'h4;
            end
        end
        checks++;
        if (g_q.size() < 3 || e_q.size() < 2 || r_q.size() < 2) begin
            errors++; $display("FAIL ws_event_count got grants=%0d mem_en=%0d rsp=%0d want >=3/2/2", g_q.size(), e_q.size(), r_q.size());
        end else begin
            checks++; if (e_q[1] - e_q[0] != 6) begin errors++; $display("FAIL ws_mem_en_spacing got=%0d want=6", e_q[1] - e_q[0]); end
            checks++; if (e_q[0] != g_q[0] + 1) begin errors++; $display("FAIL ws_mem_en_latency got=%0d want=1", e_q[0] - g_q[0]); end
            checks++; if (r_q[0] != g_q[0] + 6 || r_q[1] != g_q[1] + 6) begin
                errors++; $display("FAIL ws_rsp_latency got=%0d/%0d want=6/6", r_q[0] - g_q[0], r_q[1] - g_q[1]); end
            checks++; if (g_q[1] != r_q[0] || g_q[2] != r_q[1]) begin
                errors++; $display("FAIL ws_ready_with_rsp got ready=%0d,%0d rsp=%0d,%0d want equal", g_q[1], g_q[2], r_q[0], r_q[1]); end
            checks++; if (d_q[0] !== init_word(1) || d_q[1] !== init_word(2)) begin
                errors++; $display("FAIL ws_rdata got=%h/%h want=%h/%h", d_q[0], d_q[1], init_word(1), init_word(2)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] g; int t; logic seen; int rc;
        drain();
        set_req(0, 1'b0, 32'h14, 32'h0, 4'h0);
        wait_grant(1, g, t);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (rdy[1] !== 3'b0 || rspv[1] !== 3'b0 || rspd[1] !== 32'h0) begin
            errors++; $display("FAIL midreset_rsp got ready=%b rsp=%b data=%h want 0", rdy[1], rspv[1], rspd[1]); end
        checks++; if (men[1] !== 1'b0 || mwe[1] !== 1'b0 || maddr[1] !== 32'h0 || bsy[1] !== 1'b0 || own[1] !== 2'd0) begin
            errors++; $display("FAIL midreset_mem got en=%b we=%b addr=%h busy=%b owner=%0d want 0", men[1], mwe[1], maddr[1], bsy[1], own[1]); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen = seen | (|rspv[1]) | men[1];
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp got activity=%b want=0", seen); end
        set_req(2, 1'b0, 32'h18, 32'h0, 4'h0);
        wait_grant(1, g, t);
        checks++; if (g !== 3'b100) begin errors++; $display("FAIL midreset_regrant got=%b want=100", g); end
        rc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req_valid = '0;
            if (rspv[1] !== 3'b000) begin rc = cyc; break; end
        end
        checks++; if (rc != t + 6 || rspv[1] !== 3'b100 || rspd[1] !== init_word(6)) begin
            errors++; $display("FAIL midreset_complete got lat=%0d rsp=%b data=%h want lat=6 rsp=100 data=%h", rc - t, rspv[1], rspd[1], init_word(6)); end
    endtask

    task automatic raise(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)));
    endtask

    // Transaction-level reference: one access in flight, next arbitration at its response cycle.
    task automatic test_random(input int d);
        logic [31:0] refmem [16];
        logic        tx_act = 1'b0;
        int          tx_t = 0;
        logic [1:0]  tx_own = 2'd0;
        logic        tx_we = 1'b0;
        logic [31:0] tx_addr = '0, tx_wdata = '0, tx_rd = '0;
        logic [3:0]  tx_strb = '0;
        logic [2:0]  gl = 3'b000;
        logic [2:0]  exp_rdy, exp_rsp;
        int          starve = 0;
        int          w, n, lat, idx;
        logic        infl;
        drain();
        for (int i = 0; i < 16; i++) refmem[i] = mem[d][i];
        lat = 3 + ws(d);
        for (int step = 0; step < 400; step++) begin
            @(negedge clk);
            n = cyc;
            infl = tx_act && n > tx_t && n <= tx_t + lat;
            checks++; if (men[d] !== (tx_act && n == tx_t + 1) || mwe[d] !== (tx_act && n == tx_t + 1 && tx_we)) begin
                errors++; $display("FAIL rnd%0d_mem_strobe cyc=%0d got en=%b we=%b", d, n, men[d], mwe[d]); end
            exp_rsp = (tx_act && n == tx_t + lat) ? (3'b001 << tx_own) : 3'b000;
            checks++; if (rspv[d] !== exp_rsp) begin errors++; $display("FAIL rnd%0d_rsp_valid cyc=%0d got=%b want=%b", d, n, rspv[d], exp_rsp); end
            if (exp_rsp != 3'b000) begin
                checks++; if (rspd[d] !== tx_rd) begin errors++; $display("FAIL rnd%0d_rdata cyc=%0d got=%h want=%h", d, n, rspd[d], tx_rd); end
            end
            checks++; if (bsy[d] !== infl || own[d] !== (infl ? tx_own : 2'd0)) begin
                errors++; $display("FAIL rnd%0d_busy_owner cyc=%0d got=%b/%0d want=%b/%0d", d, n, bsy[d], own[d], infl, infl ? tx_own : 2'd0); end
            if (infl) begin
                checks++; if (maddr[d] !== tx_addr || mwdata[d] !== tx_wdata || mwstrb[d] !== tx_strb) begin
                    errors++; $display("FAIL rnd%0d_mem_fields cyc=%0d got %h/%h/%h want %h/%h/%h", d, n, maddr[d], mwdata[d], mwstrb[d], tx_addr, tx_wdata, tx_strb); end
            end
            for (int i = 0; i < 3; i++) begin
                if (gl[i]) begin
                    req_valid[i] = 1'b0;
                    gl[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) raise(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    raise(i);
                end
            end
            #1;
            w = -1;
            if (!tx_act || n >= tx_t + lat) begin
                if (req_valid[2] && starve >= 8) w = 2;
                else if (req_valid[0]) w = 0;
                else if (req_valid[1]) w = 1;
                else if (req_valid[2]) w = 2;
            end
            exp_rdy = (w >= 0) ? (3'b001 << w) : 3'b000;
            checks++; if (rdy[d] !== exp_rdy) begin errors++; $display("FAIL rnd%0d_ready cyc=%0d got=%b want=%b", d, n, rdy[d], exp_rdy); end
            if (!req_valid[2]) starve = 0;
            else if (w == 2) starve = 0;
            else if (w >= 0 && starve < 15) starve++;
            if (w >= 0) begin
                gl[w]    = 1'b1;
                tx_act   = 1'b1;
                tx_t     = n;
                tx_own   = 2'(w);
                tx_we    = req_we[w];
                tx_addr  = req_addr[w*AW +: AW];
                tx_wdata = req_wdata[w*DW +: DW];
                tx_strb  = req_wstrb[w*SW +: SW];
                idx      = int'(tx_addr[5:2]);
                tx_rd    = tx_we ? 32'h0 : refmem[idx];
                if (tx_we)
                    for (int b = 0; b < SW; b++)
                        if (tx_strb[b]) refmem[idx][8*b +: 8] = tx_wdata[8*b +: 8];
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_wait_states();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
